gcm_block_framer: RTL
=====================

# gcm_block_framer

Parametrised input framer in front of the AES-GCM engine (`aes_api`). It accepts a message as a stream of narrow beats and packs them into 128-bit blocks, with optional byte reversal. The final partial block is zero-padded. Each block carries new/last/valid-byte-count flags, a per-message bypass field and the running GCM bit length. It replaces hand-built block framing, byte reversal and `i_new`/`i_last` sequencing with one reusable block.

## Interface
- IN_BYTES, 16, bytes per input beat; legal values 1, 2, 4, 8, 16.
- BYTE_SWAP, 1, 1: message byte 0 lands in o_block[127:120] (AES order); 0: in o_block[7:0].
- BYPASS_W, 161, width of the side-band field carried with each message.
- NB_W, $clog2(IN_BYTES)+1, width of i_nbytes.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low.
- i_valid  in  1  input beat valid.
- o_ready  out  1  input beat accepted when i_valid && o_ready.
- i_data  in  8*IN_BYTES  beat data; earliest message byte in i_data[7:0].
- i_nbytes  in  NB_W  valid bytes on a last beat; 0 means IN_BYTES; ignored unless i_last.
- i_last  in  1  final beat of message.
- i_bypass  in  BYPASS_W  side-band field; sampled on first beat of message only.
- o_valid  out  1  output block valid.
- i_ready  in  1  downstream accepts block when o_valid && i_ready.
- o_block  out  128  packed block; unused bytes zero.
- o_new  out  1  first block of message.
- o_last  out  1  final block of message.
- o_nbytes  out  5  valid bytes in block, 1..16.
- o_bypass  out  BYPASS_W  message side-band field, constant across the message's blocks.
- o_len_bits  out  64  total message length in bits; meaningful when o_last.

## Operation
- State machine IDLE → MSG:
  - IDLE: the next accepted beat is the first beat of a message. It captures i_bypass, clears the byte counter and arms the new flag.
  - MSG: subsequent beats.
  - An accepted beat with i_last returns to IDLE.
  - A single-beat message goes IDLE→IDLE.
- Packing:
  - The accumulator holds up to 16 bytes; the beat index counts 0..16/IN_BYTES-1.
  - Beat k occupies message bytes k*IN_BYTES.. within the block.
  - A block completes on the last beat index or on i_last. The completed block (accumulator plus the current beat) loads into the output register, the index wraps to 0 and the accumulator clears.
  - On an i_last block, bytes beyond the valid count are zero.
- o_nbytes: 16 for non-final blocks. For the final block: (index × IN_BYTES) + effective i_nbytes.
- Length:
  - A 61-bit byte counter adds the effective byte count of each accepted beat.
  - o_len_bits = count<<3, latched with the final block.
  - The counter wraps modulo 2^61 with no error flag.
- Flags:
  - o_new is set on the first block loaded after IDLE.
  - o_last is set on the block completed by i_last.
  - o_bypass updates when a message's first block loads.
- Byte order is applied when loading the output register. BYTE_SWAP=1 reverses the 16 bytes.

## Timing
- o_ready = reset && (!o_valid || i_ready). This is combinational from i_ready, so full throughput is one beat per cycle.
- Non-completing beats are always accepted when o_ready.
- Latency: a block is presented on o_valid the cycle after its completing beat is accepted.
- Backpressure: while o_valid && !i_ready, o_block, o_new, o_last, o_nbytes, o_bypass and o_len_bits are held stable, and no beat is accepted.
- Back-to-back messages:
  - The first beat of the next message may be accepted the cycle after the previous i_last beat.
  - The previous message's o_bypass and o_len_bits stay stable until its final block is consumed.
- Reset values: o_valid 0, o_ready 0 while reset is asserted, o_block 0, o_new 0, o_last 0, o_nbytes 0, o_bypass 0, o_len_bits 0, state IDLE, accumulator and counters 0.
- Reset mid-message: everything clears immediately; the partial block and count are discarded. The first beat after deassertion starts a fresh message.

## Structure
- Shared package gcm_pkg:
  - GCM_BLOCK_W = 128, GCM_BLOCK_BYTES = 16, GCM_LEN_W = 64.
  - typedef gcm_block_t.
  - function gcm_byte_swap(gcm_block_t).
  - The framer state enum.
- No sub-module. Packing, counter and output register live in one module. Elaboration-time assertion that IN_BYTES divides 16.

## Test plan
1. IN_BYTES=16, BYTE_SWAP=1, one beat with i_data bytes D9,31,32,25,F8,84,06,E5,A5,59,09,C5,AF,F5,26,9A, i_last, i_nbytes=16 → next cycle o_valid with o_block=128'hD9313225F88406E5A55909C5AFF5269A, o_new=o_last=1, o_nbytes=16, o_len_bits=128.
2. IN_BYTES=4, 9 beats with the last beat i_nbytes=2 (34 bytes) → three blocks:
   - Block 1: o_new.
   - Block 3: o_last, o_nbytes=2, 14 zero bytes, o_len_bits=272.
3. Backpressure: i_ready held low 5 cycles with o_valid → outputs stable, o_ready=0, nothing lost; the full sequence matches a no-stall run.
4. Back-to-back messages A (i_bypass=1) and B (i_bypass=2) with no gap:
   - B's first block shows o_new=1 and o_bypass=2.
   - A's final block still shows o_bypass=1.
   - B's o_len_bits restarts from 0.
5. IN_BYTES=4: assert reset after 2 of 4 beats → o_valid=0 and o_ready=0 immediately. A following 16-byte message emits exactly one block with no stale bytes.
6. i_nbytes=0 on a last beat (IN_BYTES=8, 2 beats) → treated as 8: o_nbytes=16, o_len_bits=128.

Source files
------------

// File: rtl/gcm_pkg.sv
// Shared AES-GCM definitions: block geometry, block type, byte-order helper and the
// state encoding used by the input block framer.
package gcm_pkg;

  localparam int unsigned GCM_BLOCK_W     = 128;
  localparam int unsigned GCM_BLOCK_BYTES = 16;
  localparam int unsigned GCM_LEN_W       = 64;

  typedef logic [GCM_BLOCK_W-1:0] gcm_block_t;

  typedef enum logic {
    StIdle = 1'b0,
    StMsg  = 1'b1
  } gcm_framer_state_e;

  // Reverse the 16 bytes of a block (byte 0 <-> byte 15).
  function automatic gcm_block_t gcm_byte_swap(gcm_block_t blk);
    gcm_block_t res;
    for (int unsigned i = 0; i < GCM_BLOCK_BYTES; i++) begin
      res[8*i +: 8] = blk[8*(GCM_BLOCK_BYTES-1-i) +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/gcm_block_framer.sv
// Input framer for the AES-GCM engine. Packs a message arriving as IN_BYTES-wide beats
// into 128-bit blocks (zero-padded tail, optional byte reversal) and tags each block with
// new/last flags, valid byte count, per-message side-band field and running bit length.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   i_valid/o_ready       input beat handshake
//   i_data, i_nbytes      beat data (byte 0 in [7:0]), valid bytes on last beat (0 = full)
//   i_last, i_bypass      end-of-message marker, side-band field (first beat only)
//   o_valid/i_ready       output block handshake
//   o_block, o_new, o_last, o_nbytes, o_bypass, o_len_bits   block and its tags
module gcm_block_framer
  import gcm_pkg::*;
#(
  parameter int unsigned IN_BYTES  = 16,
  parameter bit          BYTE_SWAP = 1'b1,
  parameter int unsigned BYPASS_W  = 161,
  parameter int unsigned NB_W      = $clog2(IN_BYTES) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [8*IN_BYTES-1:0] i_data,
  input  logic [NB_W-1:0]       i_nbytes,
  input  logic                  i_last,
  input  logic [BYPASS_W-1:0]   i_bypass,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [127:0]          o_block,
  output logic                  o_new,
  output logic                  o_last,
  output logic [4:0]            o_nbytes,
  output logic [BYPASS_W-1:0]   o_bypass,
  output logic [63:0]           o_len_bits
);

  localparam int unsigned BEATS = GCM_BLOCK_BYTES / IN_BYTES;
  localparam int unsigned IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned CNT_W = GCM_LEN_W - 3;

  if (IN_BYTES == 0 || IN_BYTES > GCM_BLOCK_BYTES || (GCM_BLOCK_BYTES % IN_BYTES) != 0)
  begin : g_bad_in_bytes
    $error("gcm_block_framer: IN_BYTES must divide 16");
  end

  gcm_framer_state_e   state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  gcm_block_t          acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                new_pend_q, new_pend_d;
  logic [BYPASS_W-1:0] byp_msg_q, byp_msg_d;

  logic                valid_q;
  gcm_block_t          block_q;
  logic                new_q, last_q;
  logic [4:0]          nbytes_q;
  logic [BYPASS_W-1:0] bypass_q;
  logic [63:0]         len_q;

  logic             accept, first_beat, complete, load, blk_new;
  logic [4:0]       nb_eff, blk_nbytes;
  logic [CNT_W-1:0] cnt_sum;
  gcm_block_t       merged;

  assign o_ready    = reset && (!valid_q || i_ready);
  assign accept     = i_valid && o_ready;
  assign first_beat = (state_q == StIdle);
  assign complete   = i_last || (idx_q == IDX_W'(BEATS - 1));
  assign load       = accept && complete;
  // A block opens a message if its first beat is the current one or was seen earlier.
  assign blk_new    = first_beat || new_pend_q;

  assign nb_eff     = (i_last && i_nbytes != '0) ? 5'(i_nbytes) : 5'(IN_BYTES);
  assign blk_nbytes = i_last ? 5'(32'(idx_q) * IN_BYTES) + nb_eff : 5'd16;
  assign cnt_sum    = (first_beat ? '0 : cnt_q) + CNT_W'(nb_eff);

  // Accumulator plus current beat in message order (byte 0 in [7:0]); bytes past the
  // valid count stay zero because the accumulator is cleared after every block.
  always_comb begin
    merged = acc_q;
    for (int unsigned j = 0; j < IN_BYTES; j++) begin
      if (j < 32'(nb_eff)) begin
        merged[(32'(idx_q) * IN_BYTES + j) * 8 +: 8] = i_data[j*8 +: 8];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    new_pend_d = new_pend_q;
    byp_msg_d  = byp_msg_q;
    if (accept) begin
      state_d = i_last ? StIdle : StMsg;
      cnt_d   = i_last ? '0 : cnt_sum;
      if (first_beat) begin
        byp_msg_d = i_bypass;
      end
      if (complete) begin
        idx_d      = '0;
        acc_d      = '0;
        new_pend_d = 1'b0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
        acc_d = merged;
        if (first_beat) begin
          new_pend_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      new_pend_q <= 1'b0;
      byp_msg_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      new_pend_q <= new_pend_d;
      byp_msg_q  <= byp_msg_d;
    end
  end

  // Output register: loads only when a beat completes a block; o_ready guarantees the
  // previous block has been (or is being) consumed, so a load never overwrites a held block.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q  <= 1'b0;
      block_q  <= '0;
      new_q    <= 1'b0;
      last_q   <= 1'b0;
      nbytes_q <= '0;
      bypass_q <= '0;
      len_q    <= '0;
    end else if (load) begin
      valid_q  <= 1'b1;
      block_q  <= BYTE_SWAP ? gcm_byte_swap(merged) : merged;
      new_q    <= blk_new;
      last_q   <= i_last;
      nbytes_q <= blk_nbytes;
      if (blk_new) begin
        bypass_q <= first_beat ? i_bypass : byp_msg_q;
      end
      if (i_last) begin
        len_q <= {cnt_sum, 3'b000};
      end
    end else if (i_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign o_valid    = valid_q;
  assign o_block    = block_q;
  assign o_new      = new_q;
  assign o_last     = last_q;
  assign o_nbytes   = nbytes_q;
  assign o_bypass   = bypass_q;
  assign o_len_bits = len_q;

endmodule
